// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core loop-control path: state encoding,
// bracket opcodes and the default program-address width.
package bf_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_HALT = 2'd2
    } bf_state_e;

    // ASCII '[' and ']' as seen by the decoder
    localparam logic [7:0] BF_OP_OPEN  = 8'h5B;
    localparam logic [7:0] BF_OP_CLOSE = 8'h5D;

    localparam int BF_ADDR_WIDTH = 11;

endpackage

// File: rtl/bf_ret_stack.sv
// Return-address stack: the top entry lives in a register so it is readable in
// the same cycle; the remaining 2^DEPTH-1 entries sit in a plain memory.
module bf_ret_stack
    import bf_pkg::*;
#(
    parameter int W     = BF_ADDR_WIDTH,
    parameter int DEPTH = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int MEM_N = (1 << DEPTH) - 1;
    localparam int CW    = DEPTH + 1;

    logic [CW-1:0]    count_q, count_d;
    logic [W-1:0]     top_q, top_d;
    logic [W-1:0]     mem_q [0:MEM_N-1];
    logic [DEPTH-1:0] wr_idx, rd_idx;
    logic [W-1:0]     rd_data;

    // Entry count-1 is where the old top goes on push; count-2 is the new top on pop.
    assign wr_idx  = count_q[DEPTH-1:0] - DEPTH'(1);
    assign rd_idx  = count_q[DEPTH-1:0] - DEPTH'(2);
    assign rd_data = (rd_idx == DEPTH'(MEM_N)) ? '0 : mem_q[rd_idx];

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        if (push_i) begin
            count_d = count_q + CW'(1);
            top_d   = data_i;
        end else if (pop_i) begin
            count_d = count_q - CW'(1);
            top_d   = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            top_q   <= '0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && (count_q != '0) && (wr_idx != DEPTH'(MEM_N))) begin
            mem_q[wr_idx] <= top_q;
        end
    end

    assign top_o   = top_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(1 << DEPTH));

endmodule

// File: rtl/bf_loop_ctrl.sv
// Loop-control unit: pushes/pops return addresses, issues backward jumps and
// runs forward-skip mode. Error checking and HALT are enabled by BF_LOOP_ERR_EN.
module bf_loop_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH = BF_ADDR_WIDTH,
    parameter int DEPTH      = 7,
    parameter int SKIP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_open,
    input  logic                  op_close,
    input  logic                  cell_zero,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  jump,
    output logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  skipping,
    output logic                  error
);

    // Handshake: an op transfers on a posedge where op_valid && op_ready; op_ready
    // drops for the single jump cycle after a taken ']' and permanently in HALT.

    bf_state_e             state_q, state_d;
    logic [SKIP_WIDTH-1:0] depth_q, depth_d;
    logic                  jump_q, jump_d;
    logic [ADDR_WIDTH-1:0] jump_addr_q, jump_addr_d;

    logic                  accept, is_open, is_close;
    logic                  stk_push, stk_pop, stk_empty, stk_full;
    logic [ADDR_WIDTH-1:0] stk_top;

    assign op_ready = (state_q != ST_HALT) && !jump_q;
    assign accept   = op_valid && op_ready;
    // Both flags together is an illegal encoding and is treated as a plain op.
    assign is_open  = op_open && !op_close;
    assign is_close = op_close && !op_open;

    bf_ret_stack #(
        .W     (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc + ADDR_WIDTH'(1)),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        jump_d      = 1'b0;
        jump_addr_d = jump_addr_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept && is_open) begin
                    if (cell_zero) begin
                        depth_d = SKIP_WIDTH'(1);
                        state_d = ST_SKIP;
                    end else begin
`ifdef BF_LOOP_ERR_EN
                        if (stk_full) state_d = ST_HALT;
                        else          stk_push = 1'b1;
`else
                        stk_push = 1'b1;
`endif
                    end
                end else if (accept && is_close) begin
`ifdef BF_LOOP_ERR_EN
                    if (stk_empty) begin
                        state_d = ST_HALT;
                    end else
`endif
                    if (!cell_zero) begin
                        jump_d      = 1'b1;
                        jump_addr_d = stk_top;
                    end else begin
                        stk_pop = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (accept && is_open) begin
`ifdef BF_LOOP_ERR_EN
                    if (depth_q == '1) state_d = ST_HALT;
                    else               depth_d = depth_q + SKIP_WIDTH'(1);
`else
                    depth_d = depth_q + SKIP_WIDTH'(1);
`endif
                end else if (accept && is_close) begin
                    depth_d = depth_q - SKIP_WIDTH'(1);
                    if (depth_q == SKIP_WIDTH'(1)) state_d = ST_RUN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            depth_q     <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            jump_q      <= jump_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    assign jump      = jump_q;
    assign jump_addr = jump_addr_q;
    assign skipping  = (state_q == ST_SKIP);

`ifdef BF_LOOP_ERR_EN
    assign error = (state_q == ST_HALT);
`else
    logic unused_flags;
    assign unused_flags = stk_empty | stk_full;
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Bench for bf_loop_ctrl (DEPTH=2): directed ops, expected jump targets queued at
// issue time and checked by a monitor whenever jump is presented.
module tb_bf_loop_ctrl;

  localparam int AW = 11;
  localparam int DP = 2;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_open = 1'b0;
  logic          op_close = 1'b0;
  logic          cell_zero = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          skipping;
  logic          error;

  // bit AW set = target not checked (only the presence of a jump is expected)
  logic [AW:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  bf_loop_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DP), .SKIP_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_open(op_open), .op_close(op_close), .cell_zero(cell_zero), .pc(pc),
    .jump(jump), .jump_addr(jump_addr), .skipping(skipping), .error(error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // driver: present one op, wait (bounded) for op_ready, transfer on the next edge
  task automatic send(input logic o, input logic c, input logic z, input logic [AW-1:0] p);
    int n;
    op_open = o; op_close = c; cell_zero = z; pc = p; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: op_ready stayed 0 for pc %0d", p);
    end else begin
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op_open = 1'b0; op_close = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && jump) begin
      check("ready_in_jump_cycle", 32'(op_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_jump: jump_addr=%0d, none expected", jump_addr);
      end else begin
        logic [AW:0] e;
        e = exp_q.pop_front();
        if (!e[AW]) check("jump_addr", 32'(jump_addr), 32'(e[AW-1:0]));
      end
    end
  end

  initial begin
    do_reset();
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_jump", 32'(jump), 32'd0);
    check("rst_jump_addr", 32'(jump_addr), 32'd0);
    check("rst_skipping", 32'(skipping), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // simple loop
    send(1, 0, 0, 11'd5);
    exp_q.push_back({1'b0, 11'd6});
    send(0, 1, 0, 11'd9);
    check("jump_pulse", 32'(jump), 32'd1);
    send(0, 1, 1, 11'd9);
    check("jump_one_cycle", 32'(jump), 32'd0);

    // nested loops: pop must expose the outer return address
    send(1, 0, 0, 11'd1);
    send(1, 0, 0, 11'd3);
    exp_q.push_back({1'b0, 11'd4});
    send(0, 1, 0, 11'd6);
    send(0, 1, 1, 11'd6);
    exp_q.push_back({1'b0, 11'd2});
    send(0, 1, 0, 11'd8);
    send(0, 1, 1, 11'd8);

    // nested skip with an outer loop open (top = 31)
    send(1, 0, 0, 11'd30);
    send(1, 0, 1, 11'd20);
    check("skip_rise", 32'(skipping), 32'd1);
    send(1, 0, 1, 11'd21);
    send(0, 0, 0, 11'd22);
    check("skip_plain_op", 32'(skipping), 32'd1);
    send(1, 0, 0, 11'd23);
    send(0, 1, 0, 11'd24);
    check("skip_depth2", 32'(skipping), 32'd1);
    send(0, 1, 0, 11'd25);
    check("skip_depth1", 32'(skipping), 32'd1);
    send(0, 1, 0, 11'd26);
    check("skip_fall", 32'(skipping), 32'd0);
    exp_q.push_back({1'b0, 11'd31});
    send(0, 1, 0, 11'd40);
    send(0, 1, 1, 11'd41);

    // illegal open+close: no push, pop or jump
    send(1, 0, 0, 11'd50);
    send(1, 1, 0, 11'd52);
    check("illegal_no_skip", 32'(skipping), 32'd0);
    send(1, 1, 1, 11'd52);
    exp_q.push_back({1'b0, 11'd51});
    send(0, 1, 0, 11'd53);
    send(0, 1, 1, 11'd53);
    check("illegal_error", 32'(error), 32'd0);

    // reset mid-skip at depth 3 with one entry on the stack
    send(1, 0, 0, 11'd65);
    send(1, 0, 1, 11'd70);
    send(1, 0, 0, 11'd71);
    send(1, 0, 0, 11'd72);
    check("pre_rst_skipping", 32'(skipping), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midskip_rst_skipping", 32'(skipping), 32'd0);
    check("midskip_rst_ready", 32'(op_ready), 32'd1);
    check("midskip_rst_jump", 32'(jump), 32'd0);
    // ']' on the now-empty stack
`ifdef BF_LOOP_ERR_EN
    send(0, 1, 0, 11'd90);
    check("underflow_error", 32'(error), 32'd1);
    check("underflow_ready", 32'(op_ready), 32'd0);
    idle(3);
    check("underflow_sticky", 32'(error), 32'd1);
    check("halt_no_jump", 32'(jump), 32'd0);
`else
    exp_q.push_back({1'b1, 11'd0});
    send(0, 1, 0, 11'd90);
    idle(2);
    check("underflow_no_error", 32'(error), 32'd0);
`endif

    // overflow: five pushes into a four-entry stack
    do_reset();
    for (int i = 0; i < 4; i++) send(1, 0, 0, 11'(100 + i));
    check("four_push_error", 32'(error), 32'd0);
    check("four_push_ready", 32'(op_ready), 32'd1);
    send(1, 0, 0, 11'd104);
`ifdef BF_LOOP_ERR_EN
    check("overflow_error", 32'(error), 32'd1);
    check("overflow_ready", 32'(op_ready), 32'd0);
    idle(3);
    check("overflow_sticky_err", 32'(error), 32'd1);
    check("overflow_sticky_rdy", 32'(op_ready), 32'd0);
`else
    check("wrap_push_error", 32'(error), 32'd0);
    check("wrap_push_ready", 32'(op_ready), 32'd1);
`endif

    // skip-depth limit: depth 255 is legal, one more '[' overflows
    do_reset();
    send(1, 0, 1, 11'd200);
    for (int i = 0; i < 254; i++) send(1, 0, 0, 11'd201);
    check("depth255_error", 32'(error), 32'd0);
    check("depth255_skipping", 32'(skipping), 32'd1);
    send(1, 0, 0, 11'd202);
`ifdef BF_LOOP_ERR_EN
    check("skip_ovf_error", 32'(error), 32'd1);
    check("skip_ovf_ready", 32'(op_ready), 32'd0);
`else
    check("skip_wrap_error", 32'(error), 32'd0);
    check("skip_wrap_skipping", 32'(skipping), 32'd1);
`endif

    do_reset();
    check("final_rst_error", 32'(error), 32'd0);
    idle(2);
    check("pending_jumps", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
